// File: rtl/aes_sbox.sv
// aes_sbox: byte-wide AES forward substitution box (SubBytes).
// Used four times by the key-expansion engine for SubWord.
//
// Ports:
//   clk    in   1  rising-edge clock; only the registered output uses it
//   rst    in   1  synchronous reset, active-low (0 = reset)
//   data   in   8  byte to substitute
//   dout   out  8  combinational result S(data), zero latency, ignores rst
//   dout_q out  8  S(data) captured on the previous rising clk; 8'h00 in reset
//
// The substitution is a fully decoded constant ROM: every one of the 256
// inputs has an explicit entry, so the default arm can never be taken.
module aes_sbox (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   output logic [7:0] dout,
   output logic [7:0] dout_q
);

   logic [7:0] w_sbox;
   logic [7:0] r_dout_q;

   always_comb begin
      w_sbox = '0;
      case (data)
         8'h00: w_sbox = 8'h63;
         8'h01: w_sbox = 8'h7c;
         8'h02: w_sbox = 8'h77;
         8'h03: w_sbox = 8'h7b;
         8'h04: w_sbox = 8'hf2;
         8'h05: w_sbox = 8'h6b;
         8'h06: w_sbox = 8'h6f;
         8'h07: w_sbox = 8'hc5;
         8'h08: w_sbox = 8'h30;
         8'h09: w_sbox = 8'h01;
         8'h0a: w_sbox = 8'h67;
         8'h0b: w_sbox = 8'h2b;
         8'h0c: w_sbox = 8'hfe;
         8'h0d: w_sbox = 8'hd7;
         8'h0e: w_sbox = 8'hab;
         8'h0f: w_sbox = 8'h76;
         8'h10: w_sbox = 8'hca;
         8'h11: w_sbox = 8'h82;
         8'h12: w_sbox = 8'hc9;
         8'h13: w_sbox = 8'h7d;
         8'h14: w_sbox = 8'hfa;
         8'h15: w_sbox = 8'h59;
         8'h16: w_sbox = 8'h47;
         8'h17: w_sbox = 8'hf0;
         8'h18: w_sbox = 8'had;
         8'h19: w_sbox = 8'hd4;
         8'h1a: w_sbox = 8'ha2;
         8'h1b: w_sbox = 8'haf;
         8'h1c: w_sbox = 8'h9c;
         8'h1d: w_sbox = 8'ha4;
         8'h1e: w_sbox = 8'h72;
         8'h1f: w_sbox = 8'hc0;
         8'h20: w_sbox = 8'hb7;
         8'h21: w_sbox = 8'hfd;
         8'h22: w_sbox = 8'h93;
         8'h23: w_sbox = 8'h26;
         8'h24: w_sbox = 8'h36;
         8'h25: w_sbox = 8'h3f;
         8'h26: w_sbox = 8'hf7;
         8'h27: w_sbox = 8'hcc;
         8'h28: w_sbox = 8'h34;
         8'h29: w_sbox = 8'ha5;
         8'h2a: w_sbox = 8'he5;
         8'h2b: w_sbox = 8'hf1;
         8'h2c: w_sbox = 8'h71;
         8'h2d: w_sbox = 8'hd8;
         8'h2e: w_sbox = 8'h31;
         8'h2f: w_sbox = 8'h15;
         8'h30: w_sbox = 8'h04;
         8'h31: w_sbox = 8'hc7;
         8'h32: w_sbox = 8'h23;
         8'h33: w_sbox = 8'hc3;
         8'h34: w_sbox = 8'h18;
         8'h35: w_sbox = 8'h96;
         8'h36: w_sbox = 8'h05;
         8'h37: w_sbox = 8'h9a;
         8'h38: w_sbox = 8'h07;
         8'h39: w_sbox = 8'h12;
         8'h3a: w_sbox = 8'h80;
         8'h3b: w_sbox = 8'he2;
         8'h3c: w_sbox = 8'heb;
         8'h3d: w_sbox = 8'h27;
         8'h3e: w_sbox = 8'hb2;
         8'h3f: w_sbox = 8'h75;
         8'h40: w_sbox = 8'h09;
         8'h41: w_sbox = 8'h83;
         8'h42: w_sbox = 8'h2c;
         8'h43: w_sbox = 8'h1a;
         8'h44: w_sbox = 8'h1b;
         8'h45: w_sbox = 8'h6e;
         8'h46: w_sbox = 8'h5a;
         8'h47: w_sbox = 8'ha0;
         8'h48: w_sbox = 8'h52;
         8'h49: w_sbox = 8'h3b;
         8'h4a: w_sbox = 8'hd6;
         8'h4b: w_sbox = 8'hb3;
         8'h4c: w_sbox = 8'h29;
         8'h4d: w_sbox = 8'he3;
         8'h4e: w_sbox = 8'h2f;
         8'h4f: w_sbox = 8'h84;
         8'h50: w_sbox = 8'h53;
         8'h51: w_sbox = 8'hd1;
         8'h52: w_sbox = 8'h00;
         8'h53: w_sbox = 8'hed;
         8'h54: w_sbox = 8'h20;
         8'h55: w_sbox = 8'hfc;
         8'h56: w_sbox = 8'hb1;
         8'h57: w_sbox = 8'h5b;
         8'h58: w_sbox = 8'h6a;
         8'h59: w_sbox = 8'hcb;
         8'h5a: w_sbox = 8'hbe;
         8'h5b: w_sbox = 8'h39;
         8'h5c: w_sbox = 8'h4a;
         8'h5d: w_sbox = 8'h4c;
         8'h5e: w_sbox = 8'h58;
         8'h5f: w_sbox = 8'hcf;
         8'h60: w_sbox = 8'hd0;
         8'h61: w_sbox = 8'hef;
         8'h62: w_sbox = 8'haa;
         8'h63: w_sbox = 8'hfb;
         8'h64: w_sbox = 8'h43;
         8'h65: w_sbox = 8'h4d;
         8'h66: w_sbox = 8'h33;
         8'h67: w_sbox = 8'h85;
         8'h68: w_sbox = 8'h45;
         8'h69: w_sbox = 8'hf9;
         8'h6a: w_sbox = 8'h02;
         8'h6b: w_sbox = 8'h7f;
         8'h6c: w_sbox = 8'h50;
         8'h6d: w_sbox = 8'h3c;
         8'h6e: w_sbox = 8'h9f;
         8'h6f: w_sbox = 8'ha8;
         8'h70: w_sbox = 8'h51;
         8'h71: w_sbox = 8'ha3;
         8'h72: w_sbox = 8'h40;
         8'h73: w_sbox = 8'h8f;
         8'h74: w_sbox = 8'h92;
         8'h75: w_sbox = 8'h9d;
         8'h76: w_sbox = 8'h38;
         8'h77: w_sbox = 8'hf5;
         8'h78: w_sbox = 8'hbc;
         8'h79: w_sbox = 8'hb6;
         8'h7a: w_sbox = 8'hda;
         8'h7b: w_sbox = 8'h21;
         8'h7c: w_sbox = 8'h10;
         8'h7d: w_sbox = 8'hff;
         8'h7e: w_sbox = 8'hf3;
         8'h7f: w_sbox = 8'hd2;
         8'h80: w_sbox = 8'hcd;
         8'h81: w_sbox = 8'h0c;
         8'h82: w_sbox = 8'h13;
         8'h83: w_sbox = 8'hec;
         8'h84: w_sbox = 8'h5f;
         8'h85: w_sbox = 8'h97;
         8'h86: w_sbox = 8'h44;
         8'h87: w_sbox = 8'h17;
         8'h88: w_sbox = 8'hc4;
         8'h89: w_sbox = 8'ha7;
         8'h8a: w_sbox = 8'h7e;
         8'h8b: w_sbox = 8'h3d;
         8'h8c: w_sbox = 8'h64;
         8'h8d: w_sbox = 8'h5d;
         8'h8e: w_sbox = 8'h19;
         8'h8f: w_sbox = 8'h73;
         8'h90: w_sbox = 8'h60;
         8'h91: w_sbox = 8'h81;
         8'h92: w_sbox = 8'h4f;
         8'h93: w_sbox = 8'hdc;
         8'h94: w_sbox = 8'h22;
         8'h95: w_sbox = 8'h2a;
         8'h96: w_sbox = 8'h90;
         8'h97: w_sbox = 8'h88;
         8'h98: w_sbox = 8'h46;
         8'h99: w_sbox = 8'hee;
         8'h9a: w_sbox = 8'hb8;
         8'h9b: w_sbox = 8'h14;
         8'h9c: w_sbox = 8'hde;
         8'h9d: w_sbox = 8'h5e;
         8'h9e: w_sbox = 8'h0b;
         8'h9f: w_sbox = 8'hdb;
         8'ha0: w_sbox = 8'he0;
         8'ha1: w_sbox = 8'h32;
         8'ha2: w_sbox = 8'h3a;
         8'ha3: w_sbox = 8'h0a;
         8'ha4: w_sbox = 8'h49;
         8'ha5: w_sbox = 8'h06;
         8'ha6: w_sbox = 8'h24;
         8'ha7: w_sbox = 8'h5c;
         8'ha8: w_sbox = 8'hc2;
         8'ha9: w_sbox = 8'hd3;
         8'haa: w_sbox = 8'hac;
         8'hab: w_sbox = 8'h62;
         8'hac: w_sbox = 8'h91;
         8'had: w_sbox = 8'h95;
         8'hae: w_sbox = 8'he4;
         8'haf: w_sbox = 8'h79;
         8'hb0: w_sbox = 8'he7;
         8'hb1: w_sbox = 8'hc8;
         8'hb2: w_sbox = 8'h37;
         8'hb3: w_sbox = 8'h6d;
         8'hb4: w_sbox = 8'h8d;
         8'hb5: w_sbox = 8'hd5;
         8'hb6: w_sbox = 8'h4e;
         8'hb7: w_sbox = 8'ha9;
         8'hb8: w_sbox = 8'h6c;
         8'hb9: w_sbox = 8'h56;
         8'hba: w_sbox = 8'hf4;
         8'hbb: w_sbox = 8'hea;
         8'hbc: w_sbox = 8'h65;
         8'hbd: w_sbox = 8'h7a;
         8'hbe: w_sbox = 8'hae;
         8'hbf: w_sbox = 8'h08;
         8'hc0: w_sbox = 8'hba;
         8'hc1: w_sbox = 8'h78;
         8'hc2: w_sbox = 8'h25;
         8'hc3: w_sbox = 8'h2e;
         8'hc4: w_sbox = 8'h1c;
         8'hc5: w_sbox = 8'ha6;
         8'hc6: w_sbox = 8'hb4;
         8'hc7: w_sbox = 8'hc6;
         8'hc8: w_sbox = 8'he8;
         8'hc9: w_sbox = 8'hdd;
         8'hca: w_sbox = 8'h74;
         8'hcb: w_sbox = 8'h1f;
         8'hcc: w_sbox = 8'h4b;
         8'hcd: w_sbox = 8'hbd;
         8'hce: w_sbox = 8'h8b;
         8'hcf: w_sbox = 8'h8a;
         8'hd0: w_sbox = 8'h70;
         8'hd1: w_sbox = 8'h3e;
         8'hd2: w_sbox = 8'hb5;
         8'hd3: w_sbox = 8'h66;
         8'hd4: w_sbox = 8'h48;
         8'hd5: w_sbox = 8'h03;
         8'hd6: w_sbox = 8'hf6;
         8'hd7: w_sbox = 8'h0e;
         8'hd8: w_sbox = 8'h61;
         8'hd9: w_sbox = 8'h35;
         8'hda: w_sbox = 8'h57;
         8'hdb: w_sbox = 8'hb9;
         8'hdc: w_sbox = 8'h86;
         8'hdd: w_sbox = 8'hc1;
         8'hde: w_sbox = 8'h1d;
         8'hdf: w_sbox = 8'h9e;
         8'he0: w_sbox = 8'he1;
         8'he1: w_sbox = 8'hf8;
         8'he2: w_sbox = 8'h98;
         8'he3: w_sbox = 8'h11;
         8'he4: w_sbox = 8'h69;
         8'he5: w_sbox = 8'hd9;
         8'he6: w_sbox = 8'h8e;
         8'he7: w_sbox = 8'h94;
         8'he8: w_sbox = 8'h9b;
         8'he9: w_sbox = 8'h1e;
         8'hea: w_sbox = 8'h87;
         8'heb: w_sbox = 8'he9;
         8'hec: w_sbox = 8'hce;
         8'hed: w_sbox = 8'h55;
         8'hee: w_sbox = 8'h28;
         8'hef: w_sbox = 8'hdf;
         8'hf0: w_sbox = 8'h8c;
         8'hf1: w_sbox = 8'ha1;
         8'hf2: w_sbox = 8'h89;
         8'hf3: w_sbox = 8'h0d;
         8'hf4: w_sbox = 8'hbf;
         8'hf5: w_sbox = 8'he6;
         8'hf6: w_sbox = 8'h42;
         8'hf7: w_sbox = 8'h68;
         8'hf8: w_sbox = 8'h41;
         8'hf9: w_sbox = 8'h99;
         8'hfa: w_sbox = 8'h2d;
         8'hfb: w_sbox = 8'h0f;
         8'hfc: w_sbox = 8'hb0;
         8'hfd: w_sbox = 8'h54;
         8'hfe: w_sbox = 8'hbb;
         8'hff: w_sbox = 8'h16;
         default: w_sbox = 8'h00;
      endcase
   end

   // Reset clears only the pipelined copy; the combinational path stays live.
   always_ff @(posedge clk) begin
      if (!rst) r_dout_q <= '0;
      else      r_dout_q <= w_sbox;
   end

   assign dout   = w_sbox;
   assign dout_q = r_dout_q;

endmodule

// File: tb/tb_aes_sbox.sv
module tb_aes_sbox;

   logic       clk;
   logic       rst;
   logic [7:0] data [4];
   logic [7:0] dout [4];
   logic [7:0] dout_q [4];

   int unsigned n_tests;
   int unsigned n_fail;
   logic [7:0]  ref_tab [256];

   aes_sbox u_sb0 (.clk(clk), .rst(rst), .data(data[0]), .dout(dout[0]), .dout_q(dout_q[0]));
   aes_sbox u_sb1 (.clk(clk), .rst(rst), .data(data[1]), .dout(dout[1]), .dout_q(dout_q[1]));
   aes_sbox u_sb2 (.clk(clk), .rst(rst), .data(data[2]), .dout(dout[2]), .dout_q(dout_q[2]));
   aes_sbox u_sb3 (.clk(clk), .rst(rst), .data(data[3]), .dout(dout[3]), .dout_q(dout_q[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      if (a == 8'h00) return 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
      return 8'h00;
   endfunction

   function automatic logic [7:0] model_sbox(input logic [7:0] x);
      logic [7:0] b = ginv(x);
      logic [7:0] c = 8'h63;
      logic [7:0] s;
      for (int i = 0; i < 8; i++)
         s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      return s;
   endfunction

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  anc_in  [6];
      logic [7:0]  anc_out [6];
      logic [7:0]  vec_in  [4];
      logic [7:0]  vec_out [4];
      bit          seen [256];
      int unsigned distinct;
      logic [7:0]  d;
      logic [7:0]  exp_q;

      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 256; i++) ref_tab[i] = model_sbox(8'(i));

      rst = 1'b0;
      for (int k = 0; k < 4; k++) data[k] = 8'h00;
      edge_settle();
      check("reset_q", {24'h0, dout_q[0]}, 32'h0);

      anc_in  = '{8'h00, 8'h01, 8'h10, 8'h53, 8'h80, 8'hff};
      anc_out = '{8'h63, 8'h7c, 8'hca, 8'hed, 8'hcd, 8'h16};
      for (int i = 0; i < 6; i++) begin
         data[0] = anc_in[i];
         #1;
         check($sformatf("anchor_%02h", anc_in[i]), {24'h0, dout[0]}, {24'h0, anc_out[i]});
      end

      vec_in  = '{8'hcf, 8'h4f, 8'h3c, 8'h09};
      vec_out = '{8'h8a, 8'h84, 8'heb, 8'h01};
      for (int k = 0; k < 4; k++) data[k] = vec_in[k];
      #1;
      check("subword", {dout[0], dout[1], dout[2], dout[3]},
            {vec_out[0], vec_out[1], vec_out[2], vec_out[3]});
      for (int k = 1; k < 4; k++) data[k] = 8'h00;

      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      for (int i = 0; i < 256; i++) begin
         data[0] = 8'(i);
         #1;
         check($sformatf("sweep_%02h", i), {24'h0, dout[0]}, {24'h0, ref_tab[i]});
         if (dout[0] == 8'(i))  check($sformatf("fixpt_%02h", i), {24'h0, dout[0]}, 32'h100);
         if (dout[0] == ~8'(i)) check($sformatf("oppfix_%02h", i), {24'h0, dout[0]}, 32'h100);
         seen[dout[0]] = 1'b1;
      end
      distinct = 0;
      for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
      check("permutation", distinct, 256);

      rst = 1'b0;
      data[0] = 8'h53;
      for (int n = 0; n < 3; n++) begin
         edge_settle();
         check("hold_rst_q", {24'h0, dout_q[0]}, 32'h0);
         check("hold_rst_d", {24'h0, dout[0]}, 32'hed);
      end
      rst = 1'b1;
      edge_settle();
      check("release_q", {24'h0, dout_q[0]}, 32'hed);
      data[0] = 8'h00;
      #1;
      check("pre_edge_q", {24'h0, dout_q[0]}, 32'hed);
      edge_settle();
      check("latency_q", {24'h0, dout_q[0]}, 32'h63);

      data[0] = 8'h00; edge_settle(); check("stream_63", {24'h0, dout_q[0]}, 32'h63);
      data[0] = 8'h01; edge_settle(); check("stream_7c", {24'h0, dout_q[0]}, 32'h7c);
      data[0] = 8'hff; edge_settle(); check("stream_16", {24'h0, dout_q[0]}, 32'h16);
      rst = 1'b0; data[0] = 8'h10;
      edge_settle();
      check("midrst_q", {24'h0, dout_q[0]}, 32'h0);
      check("midrst_d", {24'h0, dout[0]}, 32'hca);
      rst = 1'b1;

      for (int n = 0; n < 300; n++) begin
         d = 8'($urandom);
         data[0] = d;
         rst = ($urandom_range(0, 7) != 0);
         exp_q = rst ? ref_tab[d] : 8'h00;
         #1;
         check("rand_d", {24'h0, dout[0]}, {24'h0, ref_tab[d]});
         edge_settle();
         check("rand_q", {24'h0, dout_q[0]}, {24'h0, exp_q});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
